// File: rtl/a1csa_128bits.sv
// =============================================================================
// Module  : a1csa_128bits
// Brief   : Registered add-one carry-select adder, {cout, s} = a + b + cin.
// Revision: 1.0
// =============================================================================
`default_nettype none

module a1csa_128bits #(
    parameter int N   = 128,
    parameter int BLK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         cin,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         out_valid
);

    localparam int C_NBLK = N / BLK;

    // Returns {carry_out, sum} of a BLK-bit ripple-carry addition.
    function automatic logic [BLK:0] f_ripple_add(
        input logic [BLK-1:0] x,
        input logic [BLK-1:0] y,
        input logic           ci
    );
        logic           c;
        logic [BLK-1:0] sm;
        c  = ci;
        sm = '0;
        for (int k = 0; k < BLK; k++) begin
            sm[k] = x[k] ^ y[k] ^ c;
            c     = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
        end
        return {c, sm};
    endfunction

    function automatic logic [BLK-1:0] f_incr(input logic [BLK-1:0] z);
        logic           c;
        logic [BLK-1:0] sm;
        c  = 1'b1;
        sm = '0;
        for (int k = 0; k < BLK; k++) begin
            sm[k] = z[k] ^ c;
            c     = c & z[k];
        end
        return sm;
    endfunction

    logic [N-1:0]    w_sum;
    logic [C_NBLK:0] w_carry;

    assign w_carry[0] = cin;

    if (N % BLK != 0) begin : g_param_check
        $error("a1csa_128bits: N (%0d) must be a multiple of BLK (%0d)", N, BLK);
    end

    for (genvar gi = 0; gi < C_NBLK; gi++) begin : g_blk
        if (gi == 0) begin : g_first
            logic [BLK:0] w_add;
            assign w_add          = f_ripple_add(a[BLK-1:0], b[BLK-1:0], w_carry[0]);
            assign w_sum[BLK-1:0] = w_add[BLK-1:0];
            assign w_carry[1]     = w_add[BLK];
        end else begin : g_upper
            logic [BLK:0]   w_z0;
            logic [BLK-1:0] w_z;
            logic [BLK-1:0] w_o;
            logic           w_kz;
            logic           w_ko;
            assign w_z0 = f_ripple_add(a[gi*BLK +: BLK], b[gi*BLK +: BLK], 1'b0);
            assign w_z  = w_z0[BLK-1:0];
            assign w_kz = w_z0[BLK];
            // Carry-in-1 result is z+1; it overflows only when z is all ones.
            assign w_o  = f_incr(w_z);
            assign w_ko = w_kz | (&w_z);
            assign w_sum[gi*BLK +: BLK] = w_carry[gi] ? w_o  : w_z;
            assign w_carry[gi+1]        = w_carry[gi] ? w_ko : w_kz;
        end
    end

    logic [N-1:0] s_q, s_d;
    logic         cout_q, cout_d;
    logic         out_valid_q, out_valid_d;

    always_comb begin
        s_d         = s_q;
        cout_d      = cout_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            s_d         = w_sum;
            cout_d      = w_carry[C_NBLK];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_a1csa_128bits.sv
// =============================================================================
// Module  : tb_a1csa_128bits
// Brief   : Scoreboard bench for the registered 128-bit A1CSA adder.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_a1csa_128bits;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         cin;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] s;
    logic         cout;
    logic         out_valid;

    logic [128:0] exp_q[$];
    int           checks;
    int           failures;

    localparam logic [127:0] C_ONES = {128{1'b1}};

    a1csa_128bits #(.N(128), .BLK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .s         (s),
        .cout      (cout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [128:0] act, input logic [128:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every presented result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got %h expected no output", {cout, s});
            end else begin
                check("result", {cout, s}, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [127:0] va, input logic [127:0] vb,
                        input logic vc, input logic [128:0] vexp);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        cin      = vc;
        exp_q.push_back(vexp);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] ra;
        logic [127:0] rb;
        logic         rc;
        checks   = 0;
        failures = 0;

        rst      = 1'b1;
        in_valid = 1'b1;
        a        = C_ONES;
        b        = C_ONES;
        cin      = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_s", {1'b0, s}, 129'd0);
            check("reset_cout_valid", {127'd0, cout, out_valid}, 129'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_s", {cout, s}, 129'd0);
        check("post_reset_valid", {128'd0, out_valid}, 129'd0);

        send(128'd5, 128'd7, 1'b0, 129'd12);
        send(C_ONES, 128'd0, 1'b1, {1'b1, 128'd0});
        send(C_ONES, C_ONES, 1'b1, {1'b1, C_ONES});
        send(128'hFF, 128'd1, 1'b0, 129'h100);
        send({1'b0, {127{1'b1}}}, 128'd1, 1'b0, {2'b01, 127'd0});
        send(128'd0, 128'd0, 1'b0, 129'd0);
        send(C_ONES, 128'd1, 1'b0, {1'b1, 128'd0});
        send({1'b1, 127'd0}, {1'b1, 127'd0}, 1'b0, {1'b1, 128'd0});
        send(128'h00FF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd0, 1'b1,
             129'h0_0100_0000_0000_0000_0000_0000_0000_0000);
        send(128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F,
             128'hF0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0, 1'b0, {1'b0, C_ONES});

        // Hold behaviour: idle cycles keep the last sum and drop out_valid.
        send(128'd3, 128'd4, 1'b0, 129'd7);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0;
            a        = rnd128();
            b        = rnd128();
            cin      = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("hold_s", {cout, s}, 129'd7);
            check("hold_valid", {128'd0, out_valid}, 129'd0);
        end

        // Reset mid-stream: the operands in the reset cycle yield no result.
        send(128'd1, 128'd1, 1'b0, 129'd2);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 128'd9;
        b        = 128'd9;
        cin      = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_out", {cout, s}, 129'd0);
        check("midreset_valid", {128'd0, out_valid}, 129'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_after_valid", {128'd0, out_valid}, 129'd0);

        for (int i = 0; i < 30000; i++) begin
            ra = rnd128();
            rb = ((i % 4) == 0) ? ~ra : rnd128();
            rc = 1'($urandom_range(0, 1));
            send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {128'd0, rc});
        end

        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("drain", 129'(exp_q.size()), 129'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
